// File: rtl/fetch_prefetch_pkg.sv
// fetch_prefetch_pkg: shared types and constants for the decoupled fetch stage.
//   instr_t / addr_t   : 32-bit instruction word and byte address
//   TRUE / FALSE       : 1-bit logic constants
//   FETCH_INSTR_BYTES  : PC stride between sequential fetches
//   fetch_entry_t      : one queue entry, {instr, pc}
package fetch_prefetch_pkg;

  typedef logic [31:0] instr_t;
  typedef logic [31:0] addr_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int FETCH_INSTR_BYTES = 4;

  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of an incoming
  // target are simply dropped.
  function automatic addr_t pc_align(input addr_t a);
    return a & ~addr_t'(FETCH_INSTR_BYTES - 1);
  endfunction

  function automatic addr_t pc_next(input addr_t a);
    return a + addr_t'(FETCH_INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// fetch_prefetch_if: instruction-memory and decode-side signals of the fetch stage.
//   imem_rd_en / imem_addr / imem_rdata        : 1-cycle-latency instruction memory
//   instr / instr_pc / instr_valid             : queue head presented to decode
//   cfsm__instr_ready                          : decode accepts the head
//   cfsm__redirect / cfsm__redirect_pc         : flush and restart fetch
// master = fetch stage, slave = memory + decode/control environment.
interface fetch_prefetch_if;
  import fetch_prefetch_pkg::*;

  logic   imem_rd_en;
  addr_t  imem_addr;
  instr_t imem_rdata;

  instr_t instr;
  addr_t  instr_pc;
  logic   instr_valid;

  logic   cfsm__instr_ready;
  logic   cfsm__redirect;
  addr_t  cfsm__redirect_pc;

  modport master (
    output imem_rd_en, imem_addr, instr, instr_pc, instr_valid,
    input  imem_rdata, cfsm__instr_ready, cfsm__redirect, cfsm__redirect_pc
  );

  modport slave (
    input  imem_rd_en, imem_addr, instr, instr_pc, instr_valid,
    output imem_rdata, cfsm__instr_ready, cfsm__redirect, cfsm__redirect_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with flush and an unregistered head read.
//   clk, reset   : clock, synchronous active-high reset
//   flush        : empties the queue at the edge (push/pop that cycle ignored)
//   push/push_data, pop : enqueue / dequeue strobes
//   head_data    : entry at the read pointer (meaningful when count != 0)
//   count        : occupancy, log2(DEPTH)+1 bits
// Pointers are log2(DEPTH) bits and wrap naturally, so DEPTH must be a power of two.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  // Storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: decoupled instruction fetch with a DEPTH-entry prefetch queue.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_prefetch_if.master (imem request/response, decode handshake,
//                redirect from the control FSM)
// Owns the fetch PC, issues one sequential read per cycle while credit allows,
// tracks the single in-flight read and pushes its response into fetch_queue.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000,
  parameter int    DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  fetch_prefetch_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = PTR_W + 2;

  addr_t          fetch_pc;
  addr_t          inflight_pc;
  logic           inflight;
  logic [CNT_W-1:0] q_count;
  logic [OCC_W-1:0] occ;
  fetch_entry_t   head;
  fetch_entry_t   resp;
  logic           push, pop, issue;

  assign bus.instr_valid = (q_count != '0);

  // A redirect cancels the handshake: the head is flushed, not consumed.
  assign pop  = bus.instr_valid & bus.cfsm__instr_ready & ~bus.cfsm__redirect;
  assign push = inflight & ~bus.cfsm__redirect;

  // Credit: queued + in flight - leaving this cycle must stay below DEPTH,
  // so the response of anything issued now always has a slot. Counting the
  // pop lets issue resume in the very cycle the consumer unstalls.
  assign occ   = OCC_W'(q_count) + OCC_W'(inflight) - OCC_W'(pop);
  assign issue = ~reset & ~bus.cfsm__redirect & (occ < OCC_W'(DEPTH));

  assign bus.imem_rd_en = issue;
  assign bus.imem_addr  = fetch_pc;

  assign resp.instr = bus.imem_rdata;
  assign resp.pc    = inflight_pc;

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.cfsm__redirect),
    .push      (push),
    .push_data (resp),
    .pop       (pop),
    .head_data (head),
    .count     (q_count)
  );

  assign bus.instr    = head.instr;
  assign bus.instr_pc = head.pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= FALSE;
      inflight_pc <= RESET_PC;
    end else if (bus.cfsm__redirect) begin
      // Any response arriving this edge belongs to the old stream; dropping
      // inflight here is what squashes it.
      fetch_pc <= pc_align(bus.cfsm__redirect_pc);
      inflight <= FALSE;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= pc_next(fetch_pc);
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
module tb_fetch_prefetch;

  logic clk;
  logic reset;
  logic reset2;
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_prefetch_if bus ();
  fetch_prefetch_if bus2 ();

  fetch_prefetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  fetch_prefetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle-latency instruction memories: word = addr ^ A5A5A5A5
  always @(posedge clk) if (bus.imem_rd_en)  bus.imem_rdata  <= bus.imem_addr  ^ 32'hA5A5_A5A5;
  always @(posedge clk) if (bus2.imem_rd_en) bus2.imem_rdata <= bus2.imem_addr ^ 32'hA5A5_A5A5;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cfsm__instr_ready = 1'b0;
    bus.cfsm__redirect = 1'b0;
    bus.cfsm__redirect_pc = 32'h0;
    repeat (3) tick();
    #1;
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.instr_valid); end
    n_tests++; if (bus.imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0b want 0", bus.imem_rd_en); end
  endtask

  task automatic test_stream();
    reset = 1'b0;
    bus.cfsm__instr_ready = 1'b1;
    #1;
    n_tests++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL stream_first_req: got en=%0b addr=%h want en=1 addr=00000000", bus.imem_rd_en, bus.imem_addr); end
    tick(); #1;
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_no_bypass: got valid=%0b want 0", bus.instr_valid); end
    tick(); #1;
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4 * k) || bus.instr !== (32'(4 * k) ^ 32'hA5A5_A5A5)) begin
        n_fail++;
        $display("FAIL stream_seq[%0d]: got valid=%0b pc=%h instr=%h want valid=1 pc=%h instr=%h",
                 k, bus.instr_valid, bus.instr_pc, bus.instr, 32'(4 * k), 32'(4 * k) ^ 32'hA5A5_A5A5);
      end
      tick(); #1;
    end
  endtask

  task automatic test_stall();
    int nreq;
    reset = 1'b1;
    bus.cfsm__instr_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.imem_rd_en === 1'b1) begin
        n_tests++; if (bus.imem_addr !== 32'(4 * nreq)) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h want %h", nreq, bus.imem_addr, 32'(4 * nreq)); end
        nreq++;
      end
      tick();
    end
    #1;
    n_tests++; if (nreq !== 4) begin n_fail++; $display("FAIL stall_req_count: got %0d want 4", nreq); end
    n_tests++; if (bus.imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL stall_rd_en_off: got %0b want 0", bus.imem_rd_en); end
    bus.cfsm__instr_ready = 1'b1;
    #1;
    n_tests++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL stall_resume: got en=%0b addr=%h want en=1 addr=00000010", bus.imem_rd_en, bus.imem_addr); end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4 * k) || bus.instr !== (32'(4 * k) ^ 32'hA5A5_A5A5)) begin
        n_fail++;
        $display("FAIL stall_drain[%0d]: got valid=%0b pc=%h instr=%h want valid=1 pc=%h", k, bus.instr_valid, bus.instr_pc, bus.instr, 32'(4 * k));
      end
      tick(); #1;
    end
  endtask

  task automatic test_redirect();
    reset = 1'b1;
    bus.cfsm__instr_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (4) tick();
    #1;
    // three queued (0,4,8), read of C in flight
    n_tests++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL redir_pre: got valid=%0b pc=%h want valid=1 pc=00000000", bus.instr_valid, bus.instr_pc); end
    bus.cfsm__redirect = 1'b1;
    bus.cfsm__redirect_pc = 32'h0000_0103;
    bus.cfsm__instr_ready = 1'b1;
    #1;
    n_tests++; if (bus.imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL redir_no_issue: got %0b want 0", bus.imem_rd_en); end
    tick();
    bus.cfsm__redirect = 1'b0;
    #1;
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got valid=%0b want 0", bus.instr_valid); end
    n_tests++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_req: got en=%0b addr=%h want en=1 addr=00000100", bus.imem_rd_en, bus.imem_addr); end
    tick(); #1;
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale: got valid=%0b pc=%h want valid=0", bus.instr_valid, bus.instr_pc); end
    tick(); #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(32'h100 + 4 * k) || bus.instr !== (32'(32'h100 + 4 * k) ^ 32'hA5A5_A5A5)) begin
        n_fail++;
        $display("FAIL redir_target[%0d]: got valid=%0b pc=%h instr=%h want valid=1 pc=%h", k, bus.instr_valid, bus.instr_pc, bus.instr, 32'(32'h100 + 4 * k));
      end
      tick(); #1;
    end
  endtask

  task automatic test_redirect_with_ready();
    n_tests++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL rr_pre_valid: got %0b want 1", bus.instr_valid); end
    bus.cfsm__redirect = 1'b1;
    bus.cfsm__redirect_pc = 32'h0000_0040;
    bus.cfsm__instr_ready = 1'b1;
    tick();
    bus.cfsm__redirect = 1'b0;
    #1;
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rr_flush: got valid=%0b want 0", bus.instr_valid); end
    tick(); #1;
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rr_gap: got valid=%0b pc=%h want valid=0", bus.instr_valid, bus.instr_pc); end
    tick(); #1;
    n_tests++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h40) begin n_fail++; $display("FAIL rr_target: got valid=%0b pc=%h want valid=1 pc=00000040", bus.instr_valid, bus.instr_pc); end
  endtask

  task automatic test_back_to_back();
    bus.cfsm__redirect = 1'b1;
    bus.cfsm__redirect_pc = 32'h0000_0200;
    tick();
    bus.cfsm__redirect_pc = 32'h0000_0302;
    #1;
    n_tests++; if (bus.instr_valid !== 1'b0 || bus.imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL b2b_first: got valid=%0b en=%0b want 0 0", bus.instr_valid, bus.imem_rd_en); end
    tick();
    bus.cfsm__redirect = 1'b0;
    #1;
    n_tests++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h300) begin n_fail++; $display("FAIL b2b_req: got en=%0b addr=%h want en=1 addr=00000300", bus.imem_rd_en, bus.imem_addr); end
    tick(); #1;
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got valid=%0b pc=%h want valid=0", bus.instr_valid, bus.instr_pc); end
    tick(); #1;
    n_tests++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h300) begin n_fail++; $display("FAIL b2b_target: got valid=%0b pc=%h want valid=1 pc=00000300", bus.instr_valid, bus.instr_pc); end
  endtask

  task automatic test_reset_midstream();
    bus.cfsm__instr_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    repeat (4) tick();
    // credit exhausted: 3 queued + C in flight
    #1;
    n_tests++; if (bus.imem_rd_en !== 1'b0 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got en=%0b valid=%0b want 0 1", bus.imem_rd_en, bus.instr_valid); end
    reset = 1'b1;
    #1;
    n_tests++; if (bus.imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rd_en: got %0b want 0", bus.imem_rd_en); end
    tick(); #1;
    n_tests++; if (bus.instr_valid !== 1'b0 || bus.imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hold: got valid=%0b en=%0b want 0 0", bus.instr_valid, bus.imem_rd_en); end
    tick();
    reset = 1'b0;
    bus.cfsm__instr_ready = 1'b1;
    #1;
    n_tests++; if (bus.imem_rd_en !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_restart: got en=%0b addr=%h want en=1 addr=00000000", bus.imem_rd_en, bus.imem_addr); end
    tick(); #1;
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_squash: got valid=%0b pc=%h want valid=0", bus.instr_valid, bus.instr_pc); end
    tick(); #1;
    n_tests++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_mid_first: got valid=%0b pc=%h want valid=1 pc=00000000", bus.instr_valid, bus.instr_pc); end
    tick(); #1;
    n_tests++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h4) begin n_fail++; $display("FAIL rst_mid_second: got valid=%0b pc=%h want valid=1 pc=00000004", bus.instr_valid, bus.instr_pc); end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    exp_pc[3] = 32'h0000_0004;
    n_tests++; if (bus2.instr_valid !== 1'b0 || bus2.imem_rd_en !== 1'b0) begin n_fail++; $display("FAIL wrap_reset: got valid=%0b en=%0b want 0 0", bus2.instr_valid, bus2.imem_rd_en); end
    bus2.cfsm__instr_ready = 1'b1;
    reset2 = 1'b0;
    #1;
    n_tests++; if (bus2.imem_rd_en !== 1'b1 || bus2.imem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_first_req: got en=%0b addr=%h want en=1 addr=fffffff8", bus2.imem_rd_en, bus2.imem_addr); end
    tick(); tick(); #1;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (bus2.instr_valid !== 1'b1 || bus2.instr_pc !== exp_pc[k] || bus2.instr !== (exp_pc[k] ^ 32'hA5A5_A5A5)) begin
        n_fail++;
        $display("FAIL wrap_seq[%0d]: got valid=%0b pc=%h instr=%h want valid=1 pc=%h", k, bus2.instr_valid, bus2.instr_pc, bus2.instr, exp_pc[k]);
      end
      tick(); #1;
    end
  endtask

  initial begin
    reset  = 1'b1;
    reset2 = 1'b1;
    bus.cfsm__instr_ready   = 1'b0;
    bus.cfsm__redirect      = 1'b0;
    bus.cfsm__redirect_pc   = 32'h0;
    bus2.cfsm__instr_ready  = 1'b0;
    bus2.cfsm__redirect     = 1'b0;
    bus2.cfsm__redirect_pc  = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_with_ready();
    test_back_to_back();
    test_reset_midstream();
    test_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
